shift_compare_monitor: RTL
==========================

# shift_compare_monitor

Downstream checker for the blocking/nonblocking capture pair. It samples the blocking-path outputs (b, c) and the nonblocking-path outputs (d, e) over a fixed window after a start pulse. It counts cycles where the paths disagree and records the sample index of the first final-stage disagreement. The results let a bench or the DE2-70 display show, cycle-accurately, how the two assignment styles diverge.

## Interface
Parameters:
- WINDOW, 16, number of sampled cycles per measurement (2..255)
- CNT_W, 8, width of counters and index outputs; WINDOW ≤ 2^CNT_W − 1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
- start  input  1  pulse; begins a measurement when idle
- blk_b  input  1  blocking-path first stage
- blk_c  input  1  blocking-path second stage
- nbk_d  input  1  nonblocking-path first stage
- nbk_e  input  1  nonblocking-path second stage
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, results valid
- mis_first  output  CNT_W  count of samples with blk_b ≠ nbk_d
- mis_last  output  CNT_W  count of samples with blk_c ≠ nbk_e
- first_idx  output  CNT_W  sample index of first blk_c ≠ nbk_e
- first_valid  output  1  first_idx holds a recorded index

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1. On that edge, clear mis_first, mis_last, first_idx, first_valid and the sample index.
  - RUN → DONE at the edge that takes sample index WINDOW−1.
  - DONE → IDLE unconditionally.
- Sampling happens on every rising edge while in RUN, and only then. Sample index 0 is the first edge after start is accepted.
- mis_first increments when blk_b ≠ nbk_d. mis_last increments when blk_c ≠ nbk_e.
- Both counters saturate at all-ones and never wrap.
- On the first blk_c ≠ nbk_e sample, first_idx captures the sample index and first_valid is set. Later mismatches leave both unchanged.
- A start pulse in RUN or DONE is ignored. It is not queued.
- Results hold their values from DONE until the next accepted start.
- Reset, at any time including mid-RUN: state IDLE, busy=0, done=0, all counters, first_idx and first_valid = 0.

## Timing
- Edge k accepts start: busy=1 from k.
- Samples are taken at edges k+1 … k+WINDOW. The sample at edge k+j uses input values present just before that edge.
- State is DONE from edge k+WINDOW. done=1 for exactly one cycle, and outputs already include the last sample.
- State is IDLE and busy=0 from edge k+WINDOW+1. The earliest next start is accepted at k+WINDOW+1.
- A measurement therefore occupies WINDOW+1 cycles, start to idle.
- Inputs are registered stages of the same clk, so no synchronizer is needed.

## Structure
- Package shift_cmp_pkg holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2). Unused code 2'd3 recovers to IDLE.
- Package default parameters: WINDOW and CNT_W.
- Sub-module sat_counter (CNT_W wide) is instantiated twice, for mis_first and mis_last. Its ports:
  - clear (synchronous)
  - inc
  - q, which holds at all-ones
- Sample index counter and first-mismatch capture stay in the top module.

## Test plan
- Constant inputs: reset, then start with all inputs 0 for the full window, WINDOW=16. Required: done at edge k+16, mis_first=0, mis_last=0, first_valid=0.
- Alternating final stages: drive blk_c toggling every cycle and nbk_e as blk_c delayed one cycle; hold b and d equal. Required: mis_last=16, mis_first=0, first_valid=1, first_idx=0.
- Single mismatch: inject blk_c ≠ nbk_e only at sample 5 and blk_b ≠ nbk_d at samples 2 and 9. Required: mis_last=1, first_idx=5, mis_first=2.
- Saturation: set WINDOW=255 with CNT_W=4 (overriding the stated WINDOW ≤ 2^CNT_W − 1 constraint for this case only) and drive a constant mismatch. Required: both counters end at 4'hF and do not wrap.
- Start ignored: pulse start again at samples 3 and at DONE. Required: a single done pulse, and results match a single-start run.
- Reset mid-RUN: assert reset at sample 7. Required: next cycle busy=0 and all outputs 0. A following start gives a full, correct 16-sample result.

Source files
------------

// File: rtl/shift_compare_monitor_pkg.sv
// Shared state encoding and default sizing for the shift/compare monitor.
package shift_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WINDOW = 16;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/shift_compare_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter
  import shift_cmp_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      q_reg <= '0;
    end else if (inc && (q_reg != '1)) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/shift_compare_monitor.sv
// Samples the blocking and nonblocking capture paths for WINDOW cycles after start,
// counting per-stage disagreements and recording where the final stages first differ.
module shift_compare_monitor
  import shift_cmp_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             blk_b,
  input  logic             blk_c,
  input  logic             nbk_d,
  input  logic             nbk_e,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mis_first,
  output logic [CNT_W-1:0] mis_last,
  output logic [CNT_W-1:0] first_idx,
  output logic             first_valid
);

  // The sample index is sized from WINDOW alone so a long window still terminates
  // even when the result counters are narrow.
  localparam int              IDX_W    = (WINDOW < 2) ? 1 : $clog2(WINDOW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   first_idx_reg;
  logic               first_valid_reg;
  logic               busy_reg;
  logic               done_reg;

  logic accept;
  logic sampling;
  logic clear_cnt;

  assign accept    = (state_reg == IDLE) && start;
  assign sampling  = (state_reg == RUN);
  assign clear_cnt = reset || accept;

  sat_counter #(.W(CNT_W)) u_cnt_first (
    .clk   (clk),
    .clear (clear_cnt),
    .inc   (sampling && (blk_b != nbk_d)),
    .q     (mis_first)
  );

  sat_counter #(.W(CNT_W)) u_cnt_last (
    .clk   (clk),
    .clear (clear_cnt),
    .inc   (sampling && (blk_c != nbk_e)),
    .q     (mis_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      first_idx_reg   <= '0;
      first_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg       <= RUN;
            busy_reg        <= 1'b1;
            idx_reg         <= '0;
            first_idx_reg   <= '0;
            first_valid_reg <= 1'b0;
          end
        end
        RUN: begin
          if ((blk_c != nbk_e) && !first_valid_reg) begin
            first_idx_reg   <= CNT_W'(idx_reg);
            first_valid_reg <= 1'b1;
          end
          idx_reg <= idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign first_idx   = first_idx_reg;
  assign first_valid = first_valid_reg;

endmodule
